// File: rtl/uart_frame_assembler_if.sv
// uart_frame_assembler_if: received-byte strobe in, committed frame out.
// master feeds bytes and observes the frame; slave is the assembler.
interface uart_frame_assembler_if #(
  parameter int NPIXEL = 784
);
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic [NPIXEL-1:0] pixel_out;
  logic [3:0]        label_out;
  logic              frame_valid;
  logic              frame_err;
  logic [7:0]        err_count;
  logic              busy;

  modport master (
    output rx_byte,
    output rx_valid,
    input  pixel_out,
    input  label_out,
    input  frame_valid,
    input  frame_err,
    input  err_count,
    input  busy
  );

  modport slave (
    input  rx_byte,
    input  rx_valid,
    output pixel_out,
    output label_out,
    output frame_valid,
    output frame_err,
    output err_count,
    output busy
  );
endinterface

// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler: sync/label/pixels framer with 1-bit thresholding.
// Define FRAME_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_frame_assembler #(
  parameter int         NPIXEL         = 784,
  parameter int         COUNT_BIT1     = 10,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter logic [7:0] THRESH         = 8'd128,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TO_BITS        = 20
) (
  input logic                  clk,
  input logic                  reset,
  uart_frame_assembler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LABEL  = 2'd1,
    PIXELS = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam logic [COUNT_BIT1-1:0] LAST =
    COUNT_BIT1'(NPIXEL - 1);
  localparam logic [TO_BITS-1:0] TO_MAX =
    TO_BITS'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [NPIXEL-1:0]     r_shadow;
  logic [NPIXEL-1:0]     w_pix_nx;
  logic [3:0]            r_lab_sh;
  logic [COUNT_BIT1-1:0] r_cnt;
  logic [TO_BITS-1:0]    r_to;
  logic [NPIXEL-1:0]     r_pixel;
  logic [3:0]            r_label;
  logic                  r_fv;
  logic                  r_fe;
  logic [7:0]            r_errc;
  logic                  w_err;
  logic                  w_commit;
  logic                  w_pix_we;
  logic                  w_lab_we;
  logic                  w_to_hit;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]            r_xor;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_err    = 1'b0;
    w_commit = 1'b0;
    w_pix_we = 1'b0;
    w_lab_we = 1'b0;
    w_to_hit = (r_state != IDLE) && !bus.rx_valid &&
               (r_to == TO_MAX);
    unique case (r_state)
      IDLE: begin
        if (bus.rx_valid && bus.rx_byte == SYNC_BYTE)
          w_next = LABEL;
      end
      LABEL: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte <= 8'd9) begin
            w_lab_we = 1'b1;
            w_next   = PIXELS;
          end else begin
            w_err  = 1'b1;
            w_next = IDLE;
          end
        end
      end
      PIXELS: begin
        if (bus.rx_valid) begin
          w_pix_we = 1'b1;
          if (r_cnt == LAST) begin
`ifdef FRAME_CHECKSUM_EN
            w_next = CHECK;
`else
            w_commit = 1'b1;
            w_next   = IDLE;
`endif
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      CHECK: begin
        if (bus.rx_valid) begin
          w_next = IDLE;
          if (bus.rx_byte == r_xor) w_commit = 1'b1;
          else                      w_err    = 1'b1;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
    // A byte in the expiry cycle clears the condition above
    if (w_to_hit) begin
      w_err  = 1'b1;
      w_next = IDLE;
    end
  end

  // Final pixel bit must reach pixel_out on the same edge it is accepted
  always_comb begin
    w_pix_nx = r_shadow;
    if (w_pix_we) w_pix_nx[r_cnt] = (bus.rx_byte >= THRESH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_lab_sh <= '0;
      r_cnt    <= '0;
      r_to     <= '0;
      r_pixel  <= '0;
      r_label  <= '0;
      r_fv     <= 1'b0;
      r_fe     <= 1'b0;
      r_errc   <= '0;
`ifdef FRAME_CHECKSUM_EN
      r_xor    <= '0;
`endif
    end else begin
      r_fv <= w_commit;
      r_fe <= w_err;
      if (w_err && r_errc != 8'hFF) r_errc <= r_errc + 8'd1;
      if (r_state == IDLE || bus.rx_valid) r_to <= '0;
      else                                 r_to <= r_to + 1'b1;
      if (w_lab_we) begin
        r_lab_sh <= bus.rx_byte[3:0];
        r_cnt    <= '0;
`ifdef FRAME_CHECKSUM_EN
        r_xor    <= bus.rx_byte;
`endif
      end
      if (w_pix_we) begin
        r_shadow <= w_pix_nx;
        r_cnt    <= r_cnt + 1'b1;
`ifdef FRAME_CHECKSUM_EN
        r_xor    <= r_xor ^ bus.rx_byte;
`endif
      end
      if (w_commit) begin
        r_pixel <= w_pix_nx;
        r_label <= r_lab_sh;
      end
    end
  end

  assign bus.pixel_out   = r_pixel;
  assign bus.label_out   = r_label;
  assign bus.frame_valid = r_fv;
  assign bus.frame_err   = r_fe;
  assign bus.err_count   = r_errc;
  assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb_uart_frame_assembler: table vectors, random frames, corner sequences.
// Expected frames come from a frame-level model of threshold and XOR rules.
module tb_uart_frame_assembler;
  localparam int NP = 784;
  localparam int TO = 50;
`ifdef FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct {
    logic [7:0] lab;
    int         kind;
    logic [7:0] delta;
    bit         ok;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_frame_assembler_if #(.NPIXEL(NP)) bus();

  uart_frame_assembler #(
    .NPIXEL(NP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  logic [NP-1:0] m_pix;
  logic [3:0]    m_lab;
  int            m_err;
  logic [7:0]    pix [NP];
  vec_t          tv [7];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_valid) fv_cnt++;
      if (bus.frame_err) fe_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [NP-1:0] a,
                     input logic [NP-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < NP; i++) begin
      case (kind)
        0:       pix[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
        1:       pix[i] = 8'h80;
        3:       pix[i] = 8'h7F;
        default: pix[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic model(input logic [7:0] lab,
                       output logic [NP-1:0] ep,
                       output logic [7:0] x);
    ep = '0;
    x  = lab;
    for (int i = 0; i < NP; i++) begin
      ep[i] = (pix[i] >= 8'd128);
      x     = x ^ pix[i];
    end
  endtask

  task automatic run_frame(input logic [7:0] lab, input int kind,
                           input logic [7:0] delta, input bit ok,
                           input int gmax, input string nm);
    logic [NP-1:0] ep;
    logic [7:0]    x;
    int f0, e0;
    fill(kind);
    model(lab, ep, x);
    f0 = fv_cnt;
    e0 = fe_cnt;
    send_byte(8'hA5);
    send_byte(lab);
    if (lab <= 8'd9) begin
      for (int i = 0; i < NP; i++) begin
        if (gmax > 0) idle($urandom_range(0, gmax));
        send_byte(pix[i]);
      end
      if (CK) send_byte(x ^ delta);
    end
    @(negedge clk);
    chk({nm, "_lat_fv"}, bus.frame_valid, ok);
    chk({nm, "_lat_fe"}, bus.frame_err, !ok);
    if (ok) begin
      m_pix = ep;
      m_lab = lab[3:0];
    end else if (m_err < 255) begin
      m_err++;
    end
    idle(2);
    @(negedge clk);
    chk({nm, "_fv_n"}, fv_cnt - f0, ok);
    chk({nm, "_fe_n"}, fe_cnt - e0, !ok);
    chk({nm, "_pix"}, bus.pixel_out, m_pix);
    chk({nm, "_lab"}, bus.label_out, m_lab);
    chk({nm, "_err"}, bus.err_count, m_err);
    chk({nm, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    logic [NP-1:0] ep;
    logic [7:0]    x;
    logic [7:0]    lab, dl, b;
    int f0, e0;

    tv[0] = '{8'h07, 0, 8'h00, 1'b1};
    tv[1] = '{8'h0C, 0, 8'h00, 1'b0};
    tv[2] = '{8'h05, 2, 8'h01, !CK};
    tv[3] = '{8'h03, 1, 8'h00, 1'b1};
    tv[4] = '{8'h09, 3, 8'h00, 1'b1};
    tv[5] = '{8'h0A, 2, 8'h00, 1'b0};
    tv[6] = '{8'h00, 2, 8'h00, 1'b1};

    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    m_pix = '0;
    m_lab = '0;
    m_err = 0;
    idle(3);
    @(negedge clk);
    reset = 1'b0;
    idle(10);
    @(negedge clk);
    chk("rst_pix", bus.pixel_out, '0);
    chk("rst_lab", bus.label_out, 4'd0);
    chk("rst_err", bus.err_count, 8'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_fv_n", fv_cnt, 0);
    chk("rst_fe_n", fe_cnt, 0);

    for (int k = 0; k < 7; k++)
      run_frame(tv[k].lab, tv[k].kind, tv[k].delta, tv[k].ok,
                (k == 6) ? 2 : 0, $sformatf("vec%0d", k));

    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      send_byte(b);
      lab = 8'($urandom_range(0, 11));
      dl = ($urandom_range(0, 3) == 0) ?
           8'($urandom_range(1, 255)) : 8'h00;
      run_frame(lab, 2, dl, (lab <= 8'd9) && (!CK || dl == 8'h00),
                2, $sformatf("rnd%0d", k));
    end

    // stalls of TO-1 cycles in LABEL and PIXELS survive
    fill(2);
    model(8'd2, ep, x);
    send_byte(8'hA5);
    idle(TO - 1);
    send_byte(8'd2);
    for (int i = 0; i < NP; i++) begin
      if (i == 100) idle(TO - 1);
      send_byte(pix[i]);
    end
    if (CK) send_byte(x);
    @(negedge clk);
    chk("to49_fv", bus.frame_valid, 1'b1);
    m_pix = ep;
    m_lab = 4'd2;
    idle(1);
    @(negedge clk);
    chk("to49_pix", bus.pixel_out, m_pix);

    e0 = fe_cnt;
    send_byte(8'hA5);
    send_byte(8'd4);
    for (int i = 0; i < 10; i++) send_byte(pix[i]);
    idle(TO);
    @(negedge clk);
    chk("to50_fe", bus.frame_err, 1'b1);
    chk("to50_busy", bus.busy, 1'b0);
    m_err++;
    idle(2);
    @(negedge clk);
    chk("to50_fe_n", fe_cnt - e0, 1);
    chk("to50_err", bus.err_count, m_err);
    chk("to50_lab", bus.label_out, m_lab);

    fill(0);
    send_byte(8'hA5);
    send_byte(8'd6);
    for (int i = 0; i < 400; i++) send_byte(pix[i]);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_pix", bus.pixel_out, '0);
    chk("mrst_lab", bus.label_out, 4'd0);
    chk("mrst_err", bus.err_count, 8'd0);
    chk("mrst_fv", bus.frame_valid, 1'b0);
    chk("mrst_fe", bus.frame_err, 1'b0);
    m_pix = '0;
    m_lab = '0;
    m_err = 0;
    @(negedge clk);
    reset = 1'b0;
    run_frame(8'd1, 0, 8'h00, 1'b1, 0, "post_rst");

    f0 = fv_cnt;
    e0 = fe_cnt;
    for (int k = 0; k < 260; k++) begin
      send_byte(8'hA5);
      send_byte(8'hF0);
    end
    idle(2);
    @(negedge clk);
    chk("sat_err", bus.err_count, 8'hFF);
    chk("sat_fe_n", fe_cnt - e0, 260);
    chk("sat_fv_n", fv_cnt - f0, 0);
    chk("sat_pix", bus.pixel_out, m_pix);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
